// File: rtl/when_prio_select.sv
// Purpose : lowest-index priority select of CHANNELS data words, with a DEFAULT fallback when no condition is set.
// Latency : comb_out is combinational; out/out_hit/out_idx appear DEPTH-1 edges after the accepting edge.
// Backpr. : one global stall, where in_ready = !out_valid | out_ready; all stages hold (bubbles included) while stalled.
//
// Optional feature macro: WHEN_PRIO_SELECT_MISS_COUNT_EN
//   defined   -> miss_count counts accepted words with sel==0 (saturating, cleared by reset)
//   undefined -> miss_count is tied to zero and no counter is built
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   in_valid / in_ready   input handshake
//   sel [CHANNELS]        condition bits, bit 0 has the highest priority
//   data [CHANNELS*WIDTH] channel i occupies bits [i*WIDTH +: WIDTH]
//   comb_out              unregistered select result of the current sel/data
//   out_valid / out_ready output handshake
//   out, out_hit, out_idx registered result, hit flag and winning channel of the final stage
//   miss_count            16-bit count of accepted misses (see macro above)

module when_prio_select #(
    parameter int               WIDTH    = 3,
    parameter int               CHANNELS = 4,
    parameter int               DEPTH    = 2,
    parameter logic [WIDTH-1:0] DEFAULT  = '0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [CHANNELS-1:0]             sel,
    input  logic [CHANNELS*WIDTH-1:0]       data,
    output logic [WIDTH-1:0]                comb_out,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WIDTH-1:0]                out,
    output logic                            out_hit,
    output logic [$clog2(CHANNELS)-1:0]     out_idx,
    output logic [15:0]                     miss_count
);

    localparam int IDXW = $clog2(CHANNELS);

    // One pipeline stage: valid flag plus the full select outcome.
    typedef struct packed {
        logic             vld;
        logic [WIDTH-1:0] res;
        logic             hit;
        logic [IDXW-1:0]  idx;
    } stage_t;

    // ------------------------------------------------------------------
    // Priority select
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] sel_res;
    logic             sel_hit;
    logic [IDXW-1:0]  sel_idx;

    // Scanning from the highest index downwards lets each lower set bit
    // overwrite the previous candidate, so the lowest set index wins
    // without an explicit break.
    always_comb begin
        sel_res = DEFAULT;
        sel_hit = 1'b0;
        sel_idx = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (sel[i]) begin
                sel_res = data[i*WIDTH +: WIDTH];
                sel_hit = 1'b1;
                sel_idx = IDXW'(i);
            end
        end
    end

    assign comb_out = sel_res;

    // ------------------------------------------------------------------
    // Pipeline with a single global advance
    // ------------------------------------------------------------------
    stage_t pipe [DEPTH];
    logic   advance;
    logic   in_xfer;

    assign advance  = !pipe[DEPTH-1].vld || out_ready;
    assign in_ready = advance;
    assign in_xfer  = in_valid && advance;

    // Payload fields of bubbles still load the current select result; they
    // are never observed as valid but stay deterministic after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                pipe[k] <= '0;
            end
        end else if (advance) begin
            pipe[0].vld <= in_valid;
            pipe[0].res <= sel_res;
            pipe[0].hit <= sel_hit;
            pipe[0].idx <= sel_idx;
            for (int k = 1; k < DEPTH; k++) begin
                pipe[k] <= pipe[k-1];
            end
        end
    end

    assign out_valid = pipe[DEPTH-1].vld;
    assign out       = pipe[DEPTH-1].res;
    assign out_hit   = pipe[DEPTH-1].hit;
    assign out_idx   = pipe[DEPTH-1].idx;

    // ------------------------------------------------------------------
    // Optional miss counter
    // ------------------------------------------------------------------
`ifdef WHEN_PRIO_SELECT_MISS_COUNT_EN
    logic [15:0] miss_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            miss_q <= 16'h0;
        end else if (in_xfer && !sel_hit && (miss_q != 16'hFFFF)) begin
            miss_q <= miss_q + 16'd1;
        end
    end

    assign miss_count = miss_q;
`else
    logic unused_in_xfer;
    assign unused_in_xfer = in_xfer;
    assign miss_count     = 16'h0;
`endif

endmodule

// File: tb/tb_when_prio_select.sv
module tb_when_prio_select;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  sel;
    logic [11:0] data;
    logic [2:0]  comb_out;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out;
    logic        out_hit;
    logic [1:0]  out_idx;
    logic [15:0] miss_count;

    logic        in_valid1;
    logic        in_ready1;
    logic [1:0]  sel1;
    logic [5:0]  data1;
    logic [2:0]  comb_out1;
    logic        out_valid1;
    logic        out_ready1;
    logic [2:0]  out1;
    logic        out_hit1;
    logic [0:0]  out_idx1;
    logic [15:0] miss_count1;

    when_prio_select #(.WIDTH(3), .CHANNELS(4), .DEPTH(2), .DEFAULT(3'h4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .data(data), .comb_out(comb_out), .out_valid(out_valid),
        .out_ready(out_ready), .out(out), .out_hit(out_hit), .out_idx(out_idx),
        .miss_count(miss_count)
    );

    when_prio_select #(.WIDTH(3), .CHANNELS(2), .DEPTH(1), .DEFAULT(3'h4)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
        .sel(sel1), .data(data1), .comb_out(comb_out1), .out_valid(out_valid1),
        .out_ready(out_ready1), .out(out1), .out_hit(out_hit1), .out_idx(out_idx1),
        .miss_count(miss_count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [5:0]  sbq[$];          // expected {hit, idx[1:0], res[2:0]} in order
    int          exp_miss = 0;
    bit          was_reset = 1'b0;
    bit          prev_stall = 1'b0;
    bit          acc = 1'b0;
    logic [5:0]  held;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: lowest set condition bit wins, else DEFAULT with hit=0, idx=0.
    function automatic logic [5:0] ref4(input logic [3:0] s, input logic [11:0] d);
        logic       hit = 1'b0;
        logic [1:0] idx = 2'd0;
        logic [2:0] res = 3'h4;
        for (int i = 0; i < 4; i++) begin
            if (!hit && s[i]) begin
                hit = 1'b1;
                idx = 2'(i);
                res = d[i*3 +: 3];
            end
        end
        return {hit, idx, res};
    endfunction

    // One clock cycle: observe at the falling edge (inputs are stable), update
    // the scoreboard with the transfers that the coming rising edge performs.
    task automatic cycle();
        logic [5:0] e;
        logic [5:0] front;
        @(negedge clk);
        acc = 1'b0;
        e = ref4(sel, data);
        chk("comb_out", 32'(comb_out), 32'(e[2:0]));
        if (!reset) begin
            chk("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
            if (was_reset) begin
                chk("post_reset_valid", 32'(out_valid), 32'd0);
                chk("post_reset_out", 32'({out_hit, out_idx, out}), 32'd0);
            end
            if (prev_stall) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_payload", 32'({out_hit, out_idx, out}), 32'(held));
            end
            chk("miss_count", 32'(miss_count), 32'(exp_miss));
            if (out_valid && out_ready) begin
                chk("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
                if (sbq.size() != 0) begin
                    front = sbq.pop_front();
                    chk("out_word", 32'({out_hit, out_idx, out}), 32'(front));
                end
            end
            if (in_valid && in_ready) begin
                sbq.push_back(e);
                acc = 1'b1;
`ifdef WHEN_PRIO_SELECT_MISS_COUNT_EN
                if (!e[5] && exp_miss < 65535) exp_miss++;
`endif
            end
            prev_stall = out_valid && !out_ready;
            held       = {out_hit, out_idx, out};
            was_reset  = 1'b0;
        end else begin
            sbq.delete();
            exp_miss   = 0;
            was_reset  = 1'b1;
            prev_stall = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int i;
        int stalls;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sel = 4'b0101; data = 12'o7531;
        in_valid1 = 1'b0; out_ready1 = 1'b1; sel1 = 2'b00; data1 = 6'o00;
        #1;

        // Reset then idle, comb_out must follow inputs during reset.
        cycle();
        sel = 4'b0100;
        cycle();
        reset = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_miss", 32'(miss_count), 32'd0);
        chk("rst_out_valid1", 32'(out_valid1), 32'd0);
        cycle();

        // Priority: sel=1010 picks channel 1.
        in_valid = 1'b1; sel = 4'b1010; data = {3'h7, 3'h6, 3'h5, 3'h1};
        #1;
        chk("prio_comb", 32'(comb_out), 32'h5);
        cycle();
        in_valid = 1'b0;
        chk("prio_lat_early", 32'(out_valid), 32'd0);
        cycle();
        chk("prio_valid", 32'(out_valid), 32'd1);
        chk("prio_out", 32'(out), 32'h5);
        chk("prio_hit", 32'(out_hit), 32'd1);
        chk("prio_idx", 32'(out_idx), 32'd1);
        cycle();

        // Fall-through: three accepted misses.
        sel = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; data = 12'($urandom);
            cycle();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) cycle();
`ifdef WHEN_PRIO_SELECT_MISS_COUNT_EN
        chk("miss_after_3", 32'(miss_count), 32'd3);
`else
        chk("miss_after_3", 32'(miss_count), 32'd0);
`endif
        chk("fall_drained", 32'(sbq.size()), 32'd0);

        // Backpressure: words 1..4 on channel 0, 3-cycle stall once out_valid rises.
        i = 1; stalls = 0;
        for (int t = 0; t < 40 && !(i > 4 && sbq.size() == 0 && !out_valid); t++) begin
            in_valid = (i <= 4); sel = 4'b0001;
            data = 12'($urandom); data[2:0] = 3'(i);
            if (out_valid && stalls < 3) begin
                out_ready = 1'b0; stalls++;
                #0;
                chk("bp_in_ready", 32'(in_ready), 32'd0);
            end else begin
                out_ready = 1'b1;
            end
            cycle();
            if (acc) i++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("bp_all_sent", 32'(i), 32'd5);
        chk("bp_stalls", 32'(stalls), 32'd3);
        chk("bp_drained", 32'(sbq.size()), 32'd0);

        // Reset mid-stream with two words in flight.
        in_valid = 1'b1; sel = 4'b0010; data = 12'($urandom);
        cycle();
        data = 12'($urandom);
        cycle();
        in_valid = 1'b0;
        chk("mid_inflight", 32'(out_valid), 32'd1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("mid_valid_cleared", 32'(out_valid), 32'd0);
        for (int k = 0; k < 4; k++) cycle();
        chk("mid_no_stale", 32'(out_valid), 32'd0);

        // DEPTH=1, CHANNELS=2 instance.
        in_valid1 = 1'b1; sel1 = 2'b10; data1 = {3'h3, 3'h6};
        #1;
        chk("d1_comb", 32'(comb_out1), 32'h3);
        chk("d1_in_ready", 32'(in_ready1), 32'd1);
        cycle();
        in_valid1 = 1'b0;
        chk("d1_valid", 32'(out_valid1), 32'd1);
        chk("d1_out", 32'(out1), 32'h3);
        chk("d1_idx", 32'(out_idx1), 32'd1);
        chk("d1_hit", 32'(out_hit1), 32'd1);
        cycle();
        chk("d1_empty", 32'(out_valid1), 32'd0);
        chk("d1_miss", 32'(miss_count1), 32'd0);

        // Randomized traffic against the scoreboard, with occasional resets.
        for (int k = 0; k < 600; k++) begin
            reset     = ($urandom_range(0, 79) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            sel       = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            data      = 12'($urandom);
            cycle();
        end
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) cycle();
        chk("rand_drained", 32'(sbq.size()), 32'd0);
        chk("rand_idle", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
